// File: rtl/barrel_shifter4.sv
// 4-bit registered barrel shifter: rotate right/left, logical or arithmetic right shift
// by 0..3 built from a shift-by-1 stage and a shift-by-2 stage, with one cycle of latency.
module barrel_shifter4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A0,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       S0,
    input  logic       S1,
    input  logic [1:0] mode,
    input  logic       in_valid,
    output logic       Y0,
    output logic       Y1,
    output logic       Y2,
    output logic       Y3,
    output logic       out_valid
);

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_LSR = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    // Both stages keep bit 3 unchanged in arithmetic mode, so a[3] is still the original A3.
    function automatic logic [3:0] shift_by1(input logic [3:0] a, input logic [1:0] m);
        logic [3:0] r;
        case (m)
            MODE_ROR: r = {a[0], a[3:1]};
            MODE_ROL: r = {a[2:0], a[3]};
            MODE_LSR: r = {1'b0, a[3:1]};
            MODE_ASR: r = {a[3], a[3:1]};
            default:  r = a;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] shift_by2(input logic [3:0] a, input logic [1:0] m);
        logic [3:0] r;
        case (m)
            MODE_ROR: r = {a[1:0], a[3:2]};
            MODE_ROL: r = {a[1:0], a[3:2]};
            MODE_LSR: r = {2'b00, a[3:2]};
            MODE_ASR: r = {{2{a[3]}}, a[3:2]};
            default:  r = a;
        endcase
        return r;
    endfunction

    logic [3:0] a_in;
    logic [3:0] stage1;
    logic [3:0] y_d;
    logic [3:0] y_q;
    logic       vld_q;

    assign a_in   = {A3, A2, A1, A0};
    assign stage1 = S0 ? shift_by1(a_in, mode) : a_in;
    assign y_d    = S1 ? shift_by2(stage1, mode) : stage1;

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= 4'b0000;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                y_q <= y_d;
            end
        end
    end

    assign Y0        = y_q[0];
    assign Y1        = y_q[1];
    assign Y2        = y_q[2];
    assign Y3        = y_q[3];
    assign out_valid = vld_q;

endmodule

// File: tb/tb_barrel_shifter4.sv
// Randomized and directed bench for barrel_shifter4 against an index-arithmetic reference.
module tb_barrel_shifter4;

    logic       clk;
    logic       rst_n;
    logic       A0, A1, A2, A3;
    logic       S0, S1;
    logic [1:0] mode;
    logic       in_valid;
    logic       Y0, Y1, Y2, Y3;
    logic       out_valid;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    logic [3:0] exp_y;
    logic       exp_vld;

    barrel_shifter4 dut (
        .clk(clk), .rst_n(rst_n),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3),
        .S0(S0), .S1(S1), .mode(mode), .in_valid(in_valid),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each output bit picks its source bit by index arithmetic.
    function automatic logic [3:0] ref_shift(input logic [3:0] a, input int s, input logic [1:0] m);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) begin
            case (m)
                2'b00:   r[k] = a[(k + s) % 4];
                2'b01:   r[k] = a[(k - s + 4) % 4];
                2'b10:   r[k] = (k + s <= 3) ? a[(k + s) % 4] : 1'b0;
                default: r[k] = (k + s <= 3) ? a[(k + s) % 4] : a[3];
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] ybus();
        return {Y3, Y2, Y1, Y0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_y   <= 4'b0000;
            exp_vld <= 1'b0;
        end else begin
            exp_vld <= in_valid;
            if (in_valid)
                exp_y <= ref_shift({A3, A2, A1, A0}, {30'd0, S1, S0}, mode);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (ybus() !== exp_y) begin
                errors++;
                $display("FAIL model_y t=%0t got=%b exp=%b", $time, ybus(), exp_y);
            end
            checks++;
            if (out_valid !== exp_vld) begin
                errors++;
                $display("FAIL model_vld t=%0t got=%b exp=%b", $time, out_valid, exp_vld);
            end
        end
    end

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] a, input logic [1:0] s, input logic [1:0] m, input logic v);
        {A3, A2, A1, A0} = a;
        {S1, S0} = s;
        mode = m;
        in_valid = v;
    endtask

    task automatic step(input logic [3:0] a, input logic [1:0] s, input logic [1:0] m, input logic v);
        @(negedge clk);
        set_in(a, s, m, v);
    endtask

    initial begin
        rst_n = 1'b1;
        set_in(4'b1110, 2'd0, 2'b00, 1'b0);

        chk4("model_ror1", ref_shift(4'b1110, 1, 2'b00), 4'b0111);
        chk4("model_rol3", ref_shift(4'b0001, 3, 2'b01), 4'b1000);
        chk4("model_lsr2", ref_shift(4'b1000, 2, 2'b10), 4'b0010);
        chk4("model_asr2", ref_shift(4'b1000, 2, 2'b11), 4'b1110);
        chk4("model_asr3", ref_shift(4'b0110, 3, 2'b11), 4'b0000);

        #1 rst_n = 1'b0;
        #2;
        chk4("reset_y", ybus(), 4'b0000);
        chk1("reset_vld", out_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        step(4'b1110, 2'd0, 2'b00, 1'b1);
        step(4'b1110, 2'd1, 2'b00, 1'b1);
        chk4("ror_s0", ybus(), 4'b1110);
        step(4'b1110, 2'd2, 2'b00, 1'b1);
        chk4("ror_s1", ybus(), 4'b0111);
        chk1("ror_vld", out_valid, 1'b1);
        step(4'b1110, 2'd3, 2'b00, 1'b1);
        chk4("ror_s2", ybus(), 4'b1011);
        step(4'b0000, 2'd0, 2'b00, 1'b0);
        chk4("ror_s3", ybus(), 4'b1101);
        chk1("ror_vld_last", out_valid, 1'b1);

        step(4'b0001, 2'd1, 2'b01, 1'b1);
        step(4'b0001, 2'd3, 2'b01, 1'b1);
        chk4("rol_s1", ybus(), 4'b0010);
        step(4'b0000, 2'd0, 2'b00, 1'b0);
        chk4("rol_s3", ybus(), 4'b1000);

        step(4'b1000, 2'd2, 2'b10, 1'b1);
        step(4'b1000, 2'd2, 2'b11, 1'b1);
        chk4("lsr_s2", ybus(), 4'b0010);
        step(4'b0000, 2'd0, 2'b00, 1'b0);
        chk4("asr_s2", ybus(), 4'b1110);

        step(4'b1110, 2'd1, 2'b00, 1'b1);
        step(4'b0101, 2'd2, 2'b10, 1'b0);
        chk4("hold_y0", ybus(), 4'b0111);
        chk1("hold_vld0", out_valid, 1'b1);
        step(4'b1001, 2'd3, 2'b01, 1'b0);
        chk4("hold_y1", ybus(), 4'b0111);
        chk1("hold_vld1", out_valid, 1'b0);

        for (int i = 0; i < 300; i++)
            step(4'($urandom), 2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));

        for (int i = 0; i < 3; i++)
            step(4'($urandom_range(1, 15)), 2'($urandom), 2'($urandom), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk4("midrst_y", ybus(), 4'b0000);
        chk1("midrst_vld", out_valid, 1'b0);
        @(negedge clk);
        chk4("midrst_held_y", ybus(), 4'b0000);
        chk1("midrst_held_vld", out_valid, 1'b0);
        rst_n = 1'b1;
        set_in(4'b1000, 2'd2, 2'b11, 1'b1);
        step(4'b0000, 2'd0, 2'b00, 1'b0);
        chk4("post_rst_y", ybus(), 4'b1110);
        chk1("post_rst_vld", out_valid, 1'b1);

        for (int i = 0; i < 200; i++)
            step(4'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
        step(4'b0000, 2'd0, 2'b00, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter4.md
# barrel_shifter4

4-bit registered barrel shifter with scalar bit ports. It takes a 4-bit data word on A0..A3 and a 2-bit shift amount on S1:S0, applies a rotate or shift selected by `mode`, and registers the result onto Y0..Y3. It is a small datapath leaf: a single-cycle shifter stage between a bit-level source and a consumer that samples `out_valid`.

## Interface
Parameters:
- none; the data width is fixed at 4 bits and the shift amount at 2 bits.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `A0` input 1: data bit 0 (LSB).
- `A1` input 1: data bit 1.
- `A2` input 1: data bit 2.
- `A3` input 1: data bit 3 (MSB).
- `S0` input 1: shift amount bit 0 (LSB).
- `S1` input 1: shift amount bit 1 (MSB).
- `mode` input 2: operation select, decoded below.
- `in_valid` input 1: when high, the inputs are captured at the next rising edge.
- `Y0` output 1: result bit 0 (LSB), registered.
- `Y1` output 1: result bit 1, registered.
- `Y2` output 1: result bit 2, registered.
- `Y3` output 1: result bit 3 (MSB), registered.
- `out_valid` output 1: high for the cycle after an accepted input.

## Operation
- A = {A3,A2,A1,A0}; shift amount s = 2·S1 + S0 (0..3); Y = {Y3,Y2,Y1,Y0}.
- `mode` 00, rotate right (default): Y_k = A_((k+s) mod 4).
- `mode` 01, rotate left: Y_k = A_((k−s) mod 4).
- `mode` 10, logical right: Y_k = A_(k+s) if k+s ≤ 3, else 0.
- `mode` 11, arithmetic right: Y_k = A_(k+s) if k+s ≤ 3, else A3.
- s = 0 passes A through unchanged in every mode.
- Implementation: two mux stages, shift by 1 controlled by S0, then shift by 2 controlled by S1. The fill bit depends on `mode`: wrap for rotates, 0 for logical, A3 for arithmetic.
- The combinational result is captured into the Y register only when `in_valid` = 1; otherwise Y holds its value.
- No ready/backpressure: every `in_valid` cycle is accepted.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on Y0..Y3 after edge N, with `out_valid` = 1 during cycle N+1.
- `out_valid` is the registered copy of `in_valid`, so back-to-back inputs give one result per cycle.
- Reset: while `rst_n` = 0, Y0..Y3 = 0 and `out_valid` = 0 immediately, without waiting for `clk`.
- Reset release: the first capture happens on the first rising edge where `rst_n` = 1 and `in_valid` = 1.
- Reset asserted mid-stream: any in-flight result is discarded and outputs go to 0 at once.
- Y0..Y3 are glitch-free register outputs; no combinational path from the inputs to the outputs.

## Test plan
- Reset: hold `rst_n` = 0 while driving A = 1110 -> Y = 0000 and `out_valid` = 0, with no clock edge needed.
- Rotate-right sweep: A0=0, A1=1, A2=1, A3=1, `mode` 00, `in_valid` = 1, s = 0,1,2,3 on consecutive cycles -> {Y3..Y0} = 1110, 0111, 1011, 1101, each one cycle later; `out_valid` stays high.
- Rotate left: A = 0001, `mode` 01, s = 1 -> Y = 0010; s = 3 -> Y = 1000.
- Logical vs arithmetic right: A = 1000, s = 2 -> Y = 0010 with `mode` 10 and Y = 1110 with `mode` 11.
- Hold: capture A = 1110, s = 1, then drop `in_valid` and change A and s -> Y stays 0111 and `out_valid` falls after one cycle.
- Reset asserted mid-stream: assert `rst_n` = 0 between clock edges during back-to-back traffic -> Y = 0000 and `out_valid` = 0 immediately; after release, the next accepted input gives the correct result one cycle later.
